mul_final_adder: RTL and testbench

Final carry-propagate stage of the 32-bit Wallace multiplier: consumes the redundant sum/carry vector pair produced by the last carry-save reduction level and resolves it into a binary product. Two-stage pipelined (low half, then high half with carry-in), carries the reservation-station tag alongside, and holds the result in an output register until the common data bus grants it. It sits between the CSA tree and the CDB arbiter in the multiply functional unit.

---
 rtl/mul_final_adder.sv | 84 ++++++++
 tb/tb_mul_final_adder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mul_final_adder.sv
// mul_final_adder: two-stage carry-propagate adder closing the Wallace multiplier, with a CDB-handshaked output register.
// Optional feature: define MUL_FA_HI_EN to add the in_hi port and per-operation upper-word (MULH) selection.
module mul_final_adder #(
    parameter int W     = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic [TAG_W-1:0] in_tag,
`ifdef MUL_FA_HI_EN
    input  logic             in_hi,
`endif
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [31:0]      cdb_data,
    output logic [TAG_W-1:0] cdb_tag,
    output logic             busy
);
    logic             s1_v, s2_v, s1_load, s2_load;
    logic [31:0]      s1_lo, s2_data, s2_next;
    logic [TAG_W-1:0] s1_tag, s2_tag;
`ifdef MUL_FA_HI_EN
    logic             s1_c, s1_hi;
    logic [W-33:0]    s1_us, s1_uc, hi_sum;
    assign hi_sum  = s1_us + s1_uc + {{(W-33){1'b0}}, s1_c};
    assign s2_next = s1_hi ? hi_sum[31:0] : s1_lo;
`else
    logic             unused_hi;
    assign unused_hi = ^{in_sum[W-1:32], in_carry[W-1:32]};
    assign s2_next   = s1_lo;
`endif
    assign in_ready = !flush && (!s1_v || !s2_v || cdb_grant);
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = !flush && s1_v && (!s2_v || cdb_grant);
    assign cdb_req  = s2_v;
    assign cdb_data = s2_data;
    assign cdb_tag  = s2_tag;
    assign busy     = s1_v || s2_v;

    // Stage occupancy: fill on load, drain on advance/grant, squash on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= s1_load || (s1_v && !s2_load);
            s2_v <= s2_load || (s2_v && !cdb_grant);
        end
    end

    // S1 payload: resolve the low half now and keep its carry for the upper half.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_tag <= in_tag;
`ifdef MUL_FA_HI_EN
            {s1_c, s1_lo} <= {1'b0, in_sum[31:0]} + {1'b0, in_carry[31:0]};
            s1_us <= in_sum[W-1:32];
            s1_uc <= in_carry[W-1:32];
            s1_hi <= in_hi;
`else
            s1_lo <= in_sum[31:0] + in_carry[31:0];
`endif
        end
    end

    // Output register holds the selected word stable until the CDB grants it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data <= '0;
            s2_tag  <= '0;
        end else if (s2_load) begin
            s2_data <= s2_next;
            s2_tag  <= s1_tag;
        end
    end
endmodule

// File: tb/tb_mul_final_adder.sv
// tb_mul_final_adder: directed and random stimulus against a FIFO reference model of the final adder.
module tb_mul_final_adder;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_hi = 0, cdb_grant = 0;
    logic [63:0] in_sum = '0, in_carry = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, cdb_req, busy;
    logic [31:0] cdb_data;
    logic [3:0]  cdb_tag;
    int          n_vec = 0, n_err = 0, edge_n = 0;

    typedef struct { logic [31:0] d; logic [3:0] t; int k; } exp_t;
    exp_t q[$];

    mul_final_adder #(.W(64), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag),
`ifdef MUL_FA_HI_EN
        .in_hi(in_hi),
`endif
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_data(cdb_data), .cdb_tag(cdb_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [63:0] s, input logic [63:0] c, input logic h);
        logic [63:0] p;
        p = s + c;
`ifdef MUL_FA_HI_EN
        return h ? p[63:32] : p[31:0];
`else
        return p[31:0];
`endif
    endfunction

    task automatic cyc();
        logic acc, pop;
        exp_t e;
        @(negedge clk);
        chk("in_ready", {63'd0, in_ready}, {63'd0, !flush && (q.size() < 2 || cdb_grant)});
        chk("cdb_req", {63'd0, cdb_req}, {63'd0, q.size() > 0 && edge_n >= q[0].k + 1});
        chk("busy", {63'd0, busy}, {63'd0, q.size() > 0});
        if (cdb_req && q.size() > 0) begin
            chk("cdb_data", {32'd0, cdb_data}, {32'd0, q[0].d});
            chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, q[0].t});
        end
        acc = in_valid && in_ready;
        pop = cdb_req && cdb_grant && q.size() > 0;
        e.d = ref_word(in_sum, in_carry, in_hi);
        e.t = in_tag;
        @(posedge clk);
        edge_n++;
        e.k = edge_n;
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic op(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t, input logic h);
        in_valid = 1; in_sum = s; in_carry = c; in_tag = t;
`ifdef MUL_FA_HI_EN
        in_hi = h;
`else
        in_hi = h & 1'b0;
`endif
    endtask

    task automatic rnd_op();
        op({$urandom, $urandom}, {$urandom, $urandom} & ~64'd1, 4'($urandom), 1'($urandom));
    endtask

    initial begin
        #12;
        chk("rst_req", {63'd0, cdb_req}, 64'd0);
        chk("rst_data", {32'd0, cdb_data}, 64'd0);
        chk("rst_tag", {60'd0, cdb_tag}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1; rst_n = 1;
        cdb_grant = 1;
        op(64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, 0); cyc();
        in_valid = 0; repeat (3) cyc();
        op(64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, 1); cyc();
        in_valid = 0; repeat (3) cyc();
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4'd5, 0); cyc();
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4'd6, 1); cyc();
        in_valid = 0; repeat (3) cyc();
        for (int i = 1; i <= 3; i++) begin op({$urandom, $urandom}, 64'(i) << 1, 4'(i), 0); cyc(); end
        in_valid = 0; repeat (3) cyc();
        cdb_grant = 0;
        for (int i = 0; i < 5; i++) begin rnd_op(); cyc(); end
        cdb_grant = 1;
        for (int i = 0; i < 4; i++) begin rnd_op(); cyc(); end
        in_valid = 0; repeat (4) cyc();
        cdb_grant = 0;
        rnd_op(); cyc(); rnd_op(); cyc();
        flush = 1; cdb_grant = 1; rnd_op(); cyc();
        flush = 0; in_valid = 0; cyc(); cyc();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rnd_op(); else in_valid = 0;
            cdb_grant = 1'($urandom);
            flush = ($urandom_range(0, 40) == 0);
            cyc();
        end
        flush = 0; cdb_grant = 0;
        rnd_op(); cyc(); rnd_op(); cyc();
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_req", {63'd0, cdb_req}, 64'd0);
        chk("arst_data", {32'd0, cdb_data}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        q.delete();
        @(posedge clk); #1; rst_n = 1; cdb_grant = 1;
        repeat (4) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
